// File: rtl/fetch_pipe_regs_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the RV32I pipeline-register front end: the bubble
// instruction, the default reset PC, register-field bit positions inside an
// instruction word, and packed layouts of the IF/ID and ID/EX register contents.
// No ports (package).
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam int          XLEN             = 32;
    localparam int          REG_W            = 5;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             result_src;
        logic             mem_write;
        logic [XLEN-1:0]  pc;
        logic             valid;
    } idex_t;

    // Extract a 5-bit register specifier starting at bit lsb.
    function automatic logic [REG_W-1:0] reg_field(input logic [XLEN-1:0] instr,
                                                   input int lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/fetch_pipe_regs_if.sv
// -----------------------------------------------------------------------------
// fetch_pipe_regs_if
// Bundles the hazard-unit commands, imem/decoder inputs and pipeline-register
// outputs of fetch_pipe_regs.
//   master : hazard unit / imem / decoder side (drives commands, InstrF, *D ctrl)
//   slave  : fetch_pipe_regs (drives PCF, IF/ID, ID/EX fields)
// StallCount/FlushCount exist only when PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
interface fetch_pipe_regs_if;

    logic        StallPC;
    logic        StallF;
    logic        FlushF;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic        RegWriteD;
    logic        ResultSrcD;
    logic        MemWriteD;

    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [4:0]  RS1D;
    logic [4:0]  RS2D;
    logic [4:0]  RdD;
    logic [4:0]  RS1E;
    logic [4:0]  RS2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        ResultSrcE;
    logic        MemWriteE;
    logic        ValidE;
    logic [31:0] PCE;
`ifdef PERF_CNT_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    modport master (
        output StallPC, StallF, FlushF, FlushD, PCSrcE, PCTargetE, InstrF,
               RegWriteD, ResultSrcD, MemWriteD,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, RS1D, RS2D, RdD,
               RS1E, RS2E, RdE, RegWriteE, ResultSrcE, MemWriteE, ValidE, PCE
`ifdef PERF_CNT_EN
       ,input  StallCount, FlushCount
`endif
    );

    modport slave (
        input  StallPC, StallF, FlushF, FlushD, PCSrcE, PCTargetE, InstrF,
               RegWriteD, ResultSrcD, MemWriteD,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, RS1D, RS2D, RdD,
               RS1E, RS2E, RdE, RegWriteE, ResultSrcE, MemWriteE, ValidE, PCE
`ifdef PERF_CNT_EN
       ,output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/fetch_pipe_regs_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Generic pipeline register: async active-high reset to RST_VAL, synchronous
// clear to CLR_VAL (bubble), hold when enable is low. Clear beats hold.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_en      : load i_d when high (and not clearing)
//   i_clr     : load CLR_VAL on the next edge
//   i_d / o_q : data in / registered data out
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= RST_VAL;
        else if (i_clr)
            r_q <= CLR_VAL;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_pipe_regs.sv
// -----------------------------------------------------------------------------
// fetch_pipe_regs
// PC, IF/ID register and the hazard-relevant slice of ID/EX for an RV32I
// five-stage core. Executes stall/flush/redirect commands from the hazard unit.
// Ports:
//   clk    : core clock (rising edge)
//   reset  : asynchronous active-high reset
//   bus    : fetch_pipe_regs_if.slave -- commands, InstrF, decoder controls in;
//            PCF, IF/ID, RS1D/RS2D/RdD, ID/EX slice out
// Optional feature: define PERF_CNT_EN to add StallCount/FlushCount.
// -----------------------------------------------------------------------------
module fetch_pipe_regs #(
    parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_pipe_regs_if.slave      bus
);

    import rv_pipe_pkg::*;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    localparam idex_t IDEX_BUBBLE = '0;

    logic [31:0] w_pcf;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_pc_en;
    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;
    idex_t       w_idex_d;
    idex_t       w_idex_q;
    logic [4:0]  w_rs1d;
    logic [4:0]  w_rs2d;
    logic [4:0]  w_rdd;

    // ---- PC: redirect outranks stall ----
    assign w_pc_plus4 = w_pcf + 32'd4;
    assign w_pc_next  = bus.PCSrcE ? bus.PCTargetE : w_pc_plus4;
    assign w_pc_en    = bus.PCSrcE | ~bus.StallPC;

    pipe_reg #(.WIDTH(32), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_pc_en),
        .i_clr (1'b0),
        .i_d   (w_pc_next),
        .o_q   (w_pcf)
    );

    // ---- IF/ID: flush outranks stall ----
    assign w_ifid_d = '{instr: bus.InstrF, pc: w_pcf, pc_plus4: w_pc_plus4, valid: 1'b1};

    pipe_reg #(.WIDTH($bits(ifid_t)), .RST_VAL(IFID_BUBBLE), .CLR_VAL(IFID_BUBBLE)) u_ifid (
        .clk   (clk),
        .rst   (reset),
        .i_en  (~bus.StallF),
        .i_clr (bus.FlushF),
        .i_d   (w_ifid_d),
        .o_q   (w_ifid_q)
    );

    assign w_rs1d = reg_field(w_ifid_q.instr, RS1_LSB);
    assign w_rs2d = reg_field(w_ifid_q.instr, RS2_LSB);
    assign w_rdd  = reg_field(w_ifid_q.instr, RD_LSB);

    // ---- ID/EX slice: always advances; invalid IF/ID carries no side effects ----
    assign w_idex_d = '{rs1:        w_rs1d,
                        rs2:        w_rs2d,
                        rd:         w_rdd,
                        reg_write:  bus.RegWriteD  & w_ifid_q.valid,
                        result_src: bus.ResultSrcD & w_ifid_q.valid,
                        mem_write:  bus.MemWriteD  & w_ifid_q.valid,
                        pc:         w_ifid_q.pc,
                        valid:      w_ifid_q.valid};

    pipe_reg #(.WIDTH($bits(idex_t)), .RST_VAL(IDEX_BUBBLE), .CLR_VAL(IDEX_BUBBLE)) u_idex (
        .clk   (clk),
        .rst   (reset),
        .i_en  (1'b1),
        .i_clr (bus.FlushD),
        .i_d   (w_idex_d),
        .o_q   (w_idex_q)
    );

    assign bus.PCF        = w_pcf;
    assign bus.InstrD     = w_ifid_q.instr;
    assign bus.PCD        = w_ifid_q.pc;
    assign bus.PCPlus4D   = w_ifid_q.pc_plus4;
    assign bus.ValidD     = w_ifid_q.valid;
    assign bus.RS1D       = w_rs1d;
    assign bus.RS2D       = w_rs2d;
    assign bus.RdD        = w_rdd;
    assign bus.RS1E       = w_idex_q.rs1;
    assign bus.RS2E       = w_idex_q.rs2;
    assign bus.RdE        = w_idex_q.rd;
    assign bus.RegWriteE  = w_idex_q.reg_write;
    assign bus.ResultSrcE = w_idex_q.result_src;
    assign bus.MemWriteE  = w_idex_q.mem_write;
    assign bus.ValidE     = w_idex_q.valid;
    assign bus.PCE        = w_idex_q.pc;

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A redirect cycle counts as a flush, not a stall, even if StallPC is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.StallPC && !bus.PCSrcE)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bus.PCSrcE)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.StallCount = r_stall_cnt;
    assign bus.FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_pipe_regs.sv
module tb_fetch_pipe_regs;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_pipe_regs_if bus();

    fetch_pipe_regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // PC-tagged instruction memory: upper 24 bits of the word carry PC[23:0].
    function automatic logic [31:0] imem(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    always_comb bus.InstrF = imem(bus.PCF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        bus.StallPC   = 1'b0;
        bus.StallF    = 1'b0;
        bus.FlushF    = 1'b0;
        bus.FlushD    = 1'b0;
        bus.PCSrcE    = 1'b0;
        bus.PCTargetE = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_cmds();
        bus.RegWriteD  = 1'b1;
        bus.ResultSrcD = 1'b1;
        bus.MemWriteD  = 1'b0;
        #2;
        checks++; if (bus.PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h expected %h", bus.PCF, 32'h0); end
        checks++; if (bus.InstrD !== 32'h13) begin errors++; $display("FAIL reset_instrd: got %h expected %h", bus.InstrD, 32'h13); end
        checks++; if (bus.ValidD !== 1'b0 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b expected 00", bus.ValidD, bus.ValidE); end
        checks++; if (bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0 || bus.PCE !== 32'h0 || bus.RdE !== 5'd0) begin errors++; $display("FAIL reset_regs: got PCD=%h PCPlus4D=%h PCE=%h RdE=%0d expected zeros", bus.PCD, bus.PCPlus4D, bus.PCE, bus.RdE); end
`ifdef PERF_CNT_EN
        checks++; if (bus.StallCount !== 32'd0 || bus.FlushCount !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.StallCount, bus.FlushCount); end
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_instr = imem(32'(4 * (k - 1)));
            checks++; if (bus.PCF !== 32'(4 * k)) begin errors++; $display("FAIL run_pcf[%0d]: got %h expected %h", k, bus.PCF, 32'(4 * k)); end
            checks++; if (bus.InstrD !== exp_instr || bus.PCD !== 32'(4 * (k - 1)) || bus.PCPlus4D !== 32'(4 * k) || bus.ValidD !== 1'b1) begin
                errors++; $display("FAIL run_ifid[%0d]: got %h/%h/%h/%b expected %h/%h/%h/1", k, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD, exp_instr, 32'(4 * (k - 1)), 32'(4 * k));
            end
            checks++; if (bus.RS1D !== rs1_of(exp_instr) || bus.RdD !== rd_of(exp_instr)) begin errors++; $display("FAIL run_decode[%0d]: got rs1=%0d rd=%0d expected rs1=%0d rd=%0d", k, bus.RS1D, bus.RdD, rs1_of(exp_instr), rd_of(exp_instr)); end
            if (k == 1) begin
                checks++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0) begin errors++; $display("FAIL run_ex_bubble: got valid=%b rw=%b expected 0/0", bus.ValidE, bus.RegWriteE); end
            end else begin
                exp_instr = imem(32'(4 * (k - 2)));
                checks++; if (bus.RdE !== rd_of(exp_instr) || bus.PCE !== 32'(4 * (k - 2)) || bus.ValidE !== 1'b1 || bus.RegWriteE !== 1'b1 || bus.ResultSrcE !== 1'b1 || bus.MemWriteE !== 1'b0) begin
                    errors++; $display("FAIL run_ex[%0d]: got rd=%0d pce=%h v=%b rw=%b rs=%b mw=%b expected rd=%0d pce=%h v=1 rw=1 rs=1 mw=0", k, bus.RdE, bus.PCE, bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, rd_of(exp_instr), 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_load_use();
        checks++; if (bus.PCF !== 32'h10) begin errors++; $display("FAIL lu_pre_pcf: got %h expected %h", bus.PCF, 32'h10); end
        bus.StallPC = 1'b1; bus.StallF = 1'b1; bus.FlushD = 1'b1;
        tick();
        checks++; if (bus.PCF !== 32'h10) begin errors++; $display("FAIL lu_pcf_hold: got %h expected %h", bus.PCF, 32'h10); end
        checks++; if (bus.InstrD !== imem(32'hC) || bus.PCD !== 32'hC) begin errors++; $display("FAIL lu_ifid_hold: got %h/%h expected %h/%h", bus.InstrD, bus.PCD, imem(32'hC), 32'hC); end
        checks++; if (bus.ValidE !== 1'b0 || bus.RdE !== 5'd0 || bus.RegWriteE !== 1'b0 || bus.PCE !== 32'h0) begin errors++; $display("FAIL lu_ex_bubble: got v=%b rd=%0d rw=%b pce=%h expected 0/0/0/0", bus.ValidE, bus.RdE, bus.RegWriteE, bus.PCE); end
        clear_cmds();
        tick();
        checks++; if (bus.PCF !== 32'h14 || bus.InstrD !== imem(32'h10)) begin errors++; $display("FAIL lu_resume_f: got %h/%h expected %h/%h", bus.PCF, bus.InstrD, 32'h14, imem(32'h10)); end
        checks++; if (bus.PCE !== 32'hC || bus.RdE !== rd_of(imem(32'hC)) || bus.ValidE !== 1'b1) begin errors++; $display("FAIL lu_resume_ex: got pce=%h rd=%0d v=%b expected %h/%0d/1", bus.PCE, bus.RdE, bus.ValidE, 32'hC, rd_of(imem(32'hC))); end
    endtask

    task automatic test_branch();
        bus.PCSrcE = 1'b1; bus.FlushF = 1'b1; bus.FlushD = 1'b1; bus.PCTargetE = 32'h100;
        tick();
        checks++; if (bus.PCF !== 32'h100) begin errors++; $display("FAIL br_pcf: got %h expected %h", bus.PCF, 32'h100); end
        checks++; if (bus.InstrD !== 32'h13 || bus.ValidD !== 1'b0 || bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0) begin errors++; $display("FAIL br_ifid_bubble: got %h/%b/%h/%h expected 00000013/0/0/0", bus.InstrD, bus.ValidD, bus.PCD, bus.PCPlus4D); end
        checks++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0) begin errors++; $display("FAIL br_ex_bubble: got %b/%b expected 0/0", bus.ValidE, bus.RegWriteE); end
        clear_cmds();
        tick();
        checks++; if (bus.PCF !== 32'h104 || bus.InstrD !== imem(32'h100) || bus.ValidD !== 1'b1) begin errors++; $display("FAIL br_target_fetch: got %h/%h/%b expected %h/%h/1", bus.PCF, bus.InstrD, bus.ValidD, 32'h104, imem(32'h100)); end
        checks++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.ResultSrcE !== 1'b0) begin errors++; $display("FAIL br_gated_ctrl: got v=%b rw=%b rs=%b expected 0/0/0", bus.ValidE, bus.RegWriteE, bus.ResultSrcE); end
        tick();
        checks++; if (bus.ValidE !== 1'b1 || bus.PCE !== 32'h100 || bus.RegWriteE !== 1'b1) begin errors++; $display("FAIL br_target_ex: got v=%b pce=%h rw=%b expected 1/%h/1", bus.ValidE, bus.PCE, bus.RegWriteE, 32'h100); end
    endtask

    task automatic test_stall_vs_redirect();
        bus.StallPC = 1'b1; bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h200;
        tick();
        checks++; if (bus.PCF !== 32'h200) begin errors++; $display("FAIL svr_pcf: got %h expected %h", bus.PCF, 32'h200); end
`ifdef PERF_CNT_EN
        checks++; if (bus.FlushCount !== 32'd2 || bus.StallCount !== 32'd1) begin errors++; $display("FAIL svr_cnt: got stall=%0d flush=%0d expected 1/2", bus.StallCount, bus.FlushCount); end
`endif
        clear_cmds();
        bus.StallPC = 1'b1; bus.StallF = 1'b1;
        tick();
        checks++; if (bus.PCF !== 32'h200 || bus.InstrD !== imem(32'h108)) begin errors++; $display("FAIL stall_hold: got %h/%h expected %h/%h", bus.PCF, bus.InstrD, 32'h200, imem(32'h108)); end
`ifdef PERF_CNT_EN
        checks++; if (bus.StallCount !== 32'd2 || bus.FlushCount !== 32'd2) begin errors++; $display("FAIL stall_cnt: got stall=%0d flush=%0d expected 2/2", bus.StallCount, bus.FlushCount); end
`endif
    endtask

    task automatic test_flush_over_stall();
        bus.StallPC = 1'b1; bus.StallF = 1'b1; bus.FlushF = 1'b1;
        tick();
        checks++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h13 || bus.PCF !== 32'h200) begin errors++; $display("FAIL fos_ifid: got v=%b instr=%h pcf=%h expected 0/00000013/%h", bus.ValidD, bus.InstrD, bus.PCF, 32'h200); end
        clear_cmds();
    endtask

    task automatic test_async_reset();
        bus.StallPC = 1'b1; bus.StallF = 1'b1; bus.FlushD = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.PCF !== 32'h0 || bus.ValidD !== 1'b0 || bus.ValidE !== 1'b0 || bus.InstrD !== 32'h13) begin errors++; $display("FAIL areset_now: got pcf=%h vd=%b ve=%b instr=%h expected 0/0/0/00000013", bus.PCF, bus.ValidD, bus.ValidE, bus.InstrD); end
`ifdef PERF_CNT_EN
        checks++; if (bus.StallCount !== 32'd0 || bus.FlushCount !== 32'd0) begin errors++; $display("FAIL areset_cnt: got %0d/%0d expected 0/0", bus.StallCount, bus.FlushCount); end
`endif
        #1;
        reset = 1'b0;
        clear_cmds();
        tick();
        checks++; if (bus.PCF !== 32'h4 || bus.InstrD !== imem(32'h0) || bus.PCD !== 32'h0 || bus.ValidD !== 1'b1) begin errors++; $display("FAIL areset_refetch: got %h/%h/%h/%b expected 4/%h/0/1", bus.PCF, bus.InstrD, bus.PCD, bus.ValidD, imem(32'h0)); end
    endtask

    task automatic test_wrap();
        bus.PCSrcE = 1'b1; bus.PCTargetE = 32'hFFFF_FFFC;
        tick();
        checks++; if (bus.PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h expected %h", bus.PCF, 32'hFFFF_FFFC); end
        clear_cmds();
        tick();
        checks++; if (bus.PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf: got %h expected %h", bus.PCF, 32'h0); end
        checks++; if (bus.PCD !== 32'hFFFF_FFFC || bus.PCPlus4D !== 32'h0 || bus.InstrD !== imem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_ifid: got %h/%h/%h expected FFFFFFFC/0/%h", bus.PCD, bus.PCPlus4D, bus.InstrD, imem(32'hFFFF_FFFC)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_free_run();
        test_load_use();
        test_branch();
        test_stall_vs_redirect();
        test_flush_over_stall();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
